// File: rtl/hci_pkg.sv
// Shared definitions for the HCI command executor: queue widths, command and
// response descriptor field positions, error codes, FSM states and helpers.
package hci_pkg;

  localparam int CmdFifoWidth  = 64;
  localparam int TxFifoWidth   = 32;
  localparam int RxFifoWidth   = 32;
  localparam int RespFifoWidth = 32;

  // Command descriptor fields
  localparam int CMD_TID_LSB      = 3;
  localparam int CMD_TID_MSB      = 6;
  localparam int CMD_ADDR_LSB     = 16;
  localparam int CMD_ADDR_MSB     = 22;
  localparam int CMD_RNW_BIT      = 29;
  localparam int CMD_DATA_LEN_LSB = 48;
  localparam int CMD_DATA_LEN_MSB = 63;

  // Response descriptor fields
  localparam int RESP_ERR_LSB      = 28;
  localparam int RESP_ERR_MSB      = 31;
  localparam int RESP_TID_LSB      = 24;
  localparam int RESP_TID_MSB      = 27;
  localparam int RESP_DATA_LEN_LSB = 0;
  localparam int RESP_DATA_LEN_MSB = 15;

  // err_status codes
  localparam logic [3:0] ERR_SUCCESS  = 4'd0;
  localparam logic [3:0] ERR_NACK     = 4'd5;
  localparam logic [3:0] ERR_OVERFLOW = 4'd6;
  localparam logic [3:0] ERR_ABORTED  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WR_DATA   = 3'd2,
    ST_RD_DATA   = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  // ceil(len/4); the 17-bit sum keeps len=0xFFFF from wrapping.
  function automatic logic [14:0] words_for_len(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd3;
    return sum[16:2];
  endfunction

  // Bytes moved by a number of 32-bit words, clipped to the command length.
  function automatic logic [15:0] bytes_for_words(input logic [14:0] words,
                                                  input logic [15:0] len);
    logic [16:0] bytes;
    bytes = {words, 2'b00};
    return (bytes > {1'b0, len}) ? len : bytes[15:0];
  endfunction

endpackage

// File: rtl/hci_cmd_executor.sv
// HCI command executor: pops one command descriptor, requests a bus transfer,
// streams write data from the TX queue or read data into the RX queue, then
// pushes one response descriptor.
// Optional transfer watchdog: define I3C_CMD_EXEC_TIMEOUT_EN.
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where both are high; a source never drops valid or changes data
// while valid is high and ready is low.
module hci_cmd_executor
  import hci_pkg::*;
#(
  parameter int XFER_TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_fifo_rvalid_i,
  output logic                     cmd_fifo_rready_o,
  input  logic [CmdFifoWidth-1:0]  cmd_fifo_rdata_i,
  input  logic                     tx_fifo_rvalid_i,
  output logic                     tx_fifo_rready_o,
  input  logic [TxFifoWidth-1:0]   tx_fifo_rdata_i,
  output logic                     rx_fifo_wvalid_o,
  input  logic                     rx_fifo_wready_i,
  output logic [RxFifoWidth-1:0]   rx_fifo_wdata_o,
  output logic                     resp_fifo_wvalid_o,
  input  logic                     resp_fifo_wready_i,
  output logic [RespFifoWidth-1:0] resp_fifo_wdata_o,
  output logic                     xfer_valid_o,
  input  logic                     xfer_ready_i,
  output logic [6:0]               xfer_addr_o,
  output logic                     xfer_rnw_o,
  output logic [15:0]              xfer_len_o,
  output logic                     bus_tx_valid_o,
  input  logic                     bus_tx_ready_i,
  output logic [31:0]              bus_tx_data_o,
  input  logic                     bus_rx_valid_i,
  output logic                     bus_rx_ready_o,
  input  logic [31:0]              bus_rx_data_i,
  input  logic                     bus_rx_last_i,
  input  logic                     xfer_done_i,
  input  logic                     xfer_nack_i,
  output logic                     busy_o
);

  state_e      state_q, state_d;
  logic [3:0]  tid_q, tid_d;
  logic [6:0]  addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [15:0] len_q, len_d;
  logic [14:0] rem_q, rem_d;     // words still owed by the data phase
  logic [14:0] words_q, words_d; // words actually moved (saturating)
  logic        ovf_q, ovf_d;
  logic        nack_q, nack_d;
  logic        abort_q, abort_d;

  logic        rx_room, xfer_hs, tx_hs, rx_acc, done_in_phase;
  logic [14:0] words_inc;
  logic [3:0]  err_status;
  logic [15:0] resp_len;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd_fifo_rdata_i[2:0], cmd_fifo_rdata_i[15:7],
                             cmd_fifo_rdata_i[28:23], cmd_fifo_rdata_i[47:30]};

  // Progress events, derived from inputs and state so the FSM can use them
  assign rx_room       = (rem_q != '0);
  assign xfer_hs       = (state_q == ST_ISSUE) && xfer_ready_i;
  assign tx_hs         = (state_q == ST_WR_DATA) && tx_fifo_rvalid_i && bus_tx_ready_i;
  assign rx_acc        = (state_q == ST_RD_DATA) && bus_rx_valid_i &&
                         (rx_room ? rx_fifo_wready_i : 1'b1);
  assign done_in_phase = xfer_done_i && ((state_q == ST_WR_DATA) ||
                         (state_q == ST_RD_DATA) || (state_q == ST_WAIT_DONE));
  assign words_inc     = (words_q == '1) ? words_q : words_q + 15'd1;

  assign xfer_addr_o = addr_q;
  assign xfer_rnw_o  = rnw_q;
  assign xfer_len_o  = len_q;
  assign busy_o      = (state_q != ST_IDLE);

`ifdef I3C_CMD_EXEC_TIMEOUT_EN
  localparam int ToW = $clog2(XFER_TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_q, to_d;
  logic           to_active, progress;
  assign to_active = (state_q == ST_ISSUE) || (state_q == ST_WR_DATA) ||
                     (state_q == ST_RD_DATA) || (state_q == ST_WAIT_DONE);
  assign progress  = xfer_hs || tx_hs || rx_acc || done_in_phase;
`endif

  // Response fields: NACK beats abort beats overflow
  always_comb begin
    err_status = ERR_SUCCESS;
    if (nack_q)       err_status = ERR_NACK;
    else if (abort_q) err_status = ERR_ABORTED;
    else if (ovf_q)   err_status = ERR_OVERFLOW;
    resp_len = nack_q ? 16'd0 : bytes_for_words(words_q, len_q);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    len_d   = len_q;
    rem_d   = rem_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    nack_d  = nack_q;
    abort_d = abort_q;
    cmd_fifo_rready_o  = 1'b0;
    tx_fifo_rready_o   = 1'b0;
    rx_fifo_wvalid_o   = 1'b0;
    rx_fifo_wdata_o    = '0;
    resp_fifo_wvalid_o = 1'b0;
    resp_fifo_wdata_o  = '0;
    xfer_valid_o       = 1'b0;
    bus_tx_valid_o     = 1'b0;
    bus_tx_data_o      = '0;
    bus_rx_ready_o     = 1'b0;
`ifdef I3C_CMD_EXEC_TIMEOUT_EN
    to_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_fifo_rready_o = 1'b1;
        if (cmd_fifo_rvalid_i) begin
          tid_d   = cmd_fifo_rdata_i[CMD_TID_MSB:CMD_TID_LSB];
          addr_d  = cmd_fifo_rdata_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
          rnw_d   = cmd_fifo_rdata_i[CMD_RNW_BIT];
          len_d   = cmd_fifo_rdata_i[CMD_DATA_LEN_MSB:CMD_DATA_LEN_LSB];
          rem_d   = words_for_len(cmd_fifo_rdata_i[CMD_DATA_LEN_MSB:CMD_DATA_LEN_LSB]);
          words_d = '0;
          ovf_d   = 1'b0;
          nack_d  = 1'b0;
          abort_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        xfer_valid_o = 1'b1;
        if (xfer_hs) begin
          if (len_q == '0) state_d = ST_WAIT_DONE;
          else if (rnw_q)  state_d = ST_RD_DATA;
          else             state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        tx_fifo_rready_o = bus_tx_ready_i;
        bus_tx_valid_o   = tx_fifo_rvalid_i;
        bus_tx_data_o    = tx_fifo_rdata_i;
        if (tx_hs) begin
          rem_d   = rem_q - 15'd1;
          words_d = words_inc;
          if (rem_q == 15'd1) state_d = ST_WAIT_DONE;
        end
        if (xfer_done_i) begin
          nack_d  = xfer_nack_i;
          state_d = ST_RESP;
        end
      end
      ST_RD_DATA: begin
        // Once the expected words are in, keep draining the bus and drop data
        if (rx_room) begin
          bus_rx_ready_o   = rx_fifo_wready_i;
          rx_fifo_wvalid_o = bus_rx_valid_i;
          rx_fifo_wdata_o  = bus_rx_data_i;
        end else begin
          bus_rx_ready_o = 1'b1;
        end
        if (rx_acc) begin
          words_d = words_inc;
          if (rx_room) rem_d = rem_q - 15'd1;
          else         ovf_d = 1'b1;
          if (bus_rx_last_i) state_d = ST_WAIT_DONE;
        end
        if (xfer_done_i) begin
          nack_d  = xfer_nack_i;
          state_d = ST_RESP;
        end
      end
      ST_WAIT_DONE: begin
        if (xfer_done_i) begin
          nack_d  = xfer_nack_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_fifo_wvalid_o = 1'b1;
        resp_fifo_wdata_o[RESP_ERR_MSB:RESP_ERR_LSB]           = err_status;
        resp_fifo_wdata_o[RESP_TID_MSB:RESP_TID_LSB]           = tid_q;
        resp_fifo_wdata_o[RESP_DATA_LEN_MSB:RESP_DATA_LEN_LSB] = resp_len;
        if (resp_fifo_wready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef I3C_CMD_EXEC_TIMEOUT_EN
    if (to_active && !progress) begin
      if (to_q == ToW'(XFER_TIMEOUT_CYCLES - 1)) begin
        abort_d = 1'b1;
        state_d = ST_RESP;
      end else begin
        to_d = to_q + ToW'(1);
      end
    end
`endif
  end

  // State and command context registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tid_q   <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      nack_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef I3C_CMD_EXEC_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      nack_q  <= nack_d;
      abort_q <= abort_d;
`ifdef I3C_CMD_EXEC_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

endmodule
